// File: rtl/multi_param_pkg.sv
// Shared types and constants for the multi_param shift-add multiplier.
package multi_param_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 32;

    // Counter must reach WIDTH itself, hence WIDTH+1 states.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/multi_param_absval.sv
// Magnitude/sign split of one operand; the most negative value maps to 2^(WIDTH-1).
module multi_param_absval
    import multi_param_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] value_i,
    input  logic             sgn_i,
    output logic [WIDTH-1:0] mag_o,
    output logic             neg_o
);

    assign neg_o = sgn_i & value_i[WIDTH-1];
    assign mag_o = neg_o ? (~value_i + WIDTH'(1)) : value_i;

endmodule

// File: rtl/multi_param.sv
// Sequential signed/unsigned shift-add multiplier, one multiplier bit per cycle.
// Define MULTI_PARAM_EARLY_TERM_EN to finish as soon as the remaining multiplier is zero.
//
// state | meaning
// IDLE  | waiting for a start edge
// CALC  | one multiplier bit accumulated per cycle
// DONE  | result published, valid high for this one cycle
module multi_param
    import multi_param_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   mlier_i,
    input  logic [WIDTH-1:0]   mcand_i,
    input  logic               sgn_i,
    output logic [2*WIDTH-1:0] prodt_o,
    output logic               valid_o,
    output logic               busy_o
);

    localparam int CW = cnt_width(WIDTH);
    localparam int PW = 2 * WIDTH;

    state_e           state_q, state_d;
    logic             start_q;
    logic [WIDTH-1:0] mr_q, mr_d;
    logic [WIDTH-1:0] mc_q, mc_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    prodt_q, prodt_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sign_q, sign_d;
    logic             valid_q, valid_d;

    logic [WIDTH-1:0] mlier_mag, mcand_mag;
    logic             mlier_neg, mcand_neg;
    logic             start_edge;
    logic             calc_last;

    multi_param_absval #(.WIDTH(WIDTH)) u_abs_mlier (
        .value_i (mlier_i),
        .sgn_i   (sgn_i),
        .mag_o   (mlier_mag),
        .neg_o   (mlier_neg)
    );

    multi_param_absval #(.WIDTH(WIDTH)) u_abs_mcand (
        .value_i (mcand_i),
        .sgn_i   (sgn_i),
        .mag_o   (mcand_mag),
        .neg_o   (mcand_neg)
    );

    assign start_edge = start_i & ~start_q;

`ifdef MULTI_PARAM_EARLY_TERM_EN
    assign calc_last = (cnt_q == CW'(WIDTH)) || (mr_q == '0);
`else
    assign calc_last = (cnt_q == CW'(WIDTH));
`endif

    always_comb begin
        state_d = state_q;
        mr_d    = mr_q;
        mc_d    = mc_q;
        acc_d   = acc_q;
        prodt_d = prodt_q;
        cnt_d   = cnt_q;
        sign_d  = sign_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_edge) begin
                    state_d = CALC;
                    mr_d    = mlier_mag;
                    mc_d    = mcand_mag;
                    sign_d  = mlier_neg ^ mcand_neg;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            CALC: begin
                if (calc_last) begin
                    state_d = DONE;
                    prodt_d = (sign_q && acc_q != '0) ? -acc_q : acc_q;
                    valid_d = 1'b1;
                end else begin
                    if (mr_q[0]) begin
                        acc_d = acc_q + (PW'(mc_q) << cnt_q);
                    end
                    mr_d  = mr_q >> 1;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            mr_q    <= '0;
            mc_q    <= '0;
            acc_q   <= '0;
            prodt_q <= '0;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_i;
            mr_q    <= mr_d;
            mc_q    <= mc_d;
            acc_q   <= acc_d;
            prodt_q <= prodt_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
            valid_q <= valid_d;
        end
    end

    assign prodt_o = prodt_q;
    assign valid_o = valid_q;
    assign busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_multi_param.sv
// Scoreboard bench for multi_param (WIDTH=32); honours MULTI_PARAM_EARLY_TERM_EN for latency.
module tb_multi_param;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] mlier;
    logic [31:0] mcand;
    logic        sgn;
    logic [63:0] prodt;
    logic        valid;
    logic        busy;

    typedef struct {
        logic [63:0] p;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    multi_param #(.WIDTH(32)) dut (
        .clock_i (clk),
        .reset_i (rst),
        .start_i (start),
        .mlier_i (mlier),
        .mcand_i (mcand),
        .sgn_i   (sgn),
        .prodt_o (prodt),
        .valid_o (valid),
        .busy_o  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint          sa, sb_;
        longint unsigned ua, ub;
        if (s) begin
            sa  = longint'($signed(a));
            sb_ = longint'($signed(b));
            return 64'(sa * sb_);
        end
        ua = 64'(a);
        ub = 64'(b);
        return ua * ub;
    endfunction

    function automatic int ref_lat(input logic [31:0] a, input logic s);
        logic [31:0] m;
        int          l;
        m = (s && a[31]) ? (32'd0 - a) : a;
        l = 33;
`ifdef MULTI_PARAM_EARLY_TERM_EN
        l = 1;
        for (int i = 0; i < 32; i++) begin
            if (m[i]) l = i + 2;
        end
`else
        if (m == 32'd0) l = 33;
`endif
        return l;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every valid pulse.
    logic        busy_chk_next = 1'b0;
    logic [63:0] last_p        = 64'd0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            last_p        = 64'd0;
            busy_chk_next = 1'b0;
        end else begin
            if (busy_chk_next) begin
                chk("busy_after_valid", {63'd0, busy}, 64'd0);
                chk("valid_one_cycle", {63'd0, valid}, 64'd0);
                busy_chk_next = 1'b0;
            end
            if (valid === 1'b1) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_valid: got prodt %h expected no pulse (cycle %0d)", prodt, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("prodt", prodt, e.p);
                    chk("latency_cycle", 64'(cyc), 64'(e.cyc));
                    chk("busy_with_valid", {63'd0, busy}, 64'd1);
                end
                busy_chk_next = 1'b1;
            end else if (prodt !== last_p) begin
                chk("prodt_stable", prodt, last_p);
            end
            last_p = prodt;
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL idle_timeout: got busy %b expected 0", busy);
        end
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input int hold, input bit glitch);
        exp_t e;
        mlier = a;
        mcand = b;
        sgn   = s;
        start = 1'b1;
        e.p   = ref_prod(a, b, s);
        e.cyc = cyc + 1 + ref_lat(a, s);
        sb.push_back(e);
        repeat (hold) @(negedge clk);
        start = 1'b0;
        mlier = $urandom;
        mcand = $urandom;
        sgn   = $urandom_range(0, 1);
        if (glitch) begin
            repeat (4) @(negedge clk);
            start = 1'b1;
            repeat (2) @(negedge clk);
            start = 1'b0;
        end
        @(negedge clk);
        wait_idle();
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h80000000;
            2:       return 32'hffffffff;
            3:       return 32'h7fffffff;
            4:       return 32'($urandom_range(0, 255));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        exp_t e;
        rst   = 1'b1;
        start = 1'b0;
        mlier = 32'd0;
        mcand = 32'd0;
        sgn   = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_prodt", prodt, 64'd0);
        chk("reset_valid", {63'd0, valid}, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        #1 rst = 1'b0;
        @(negedge clk);

        do_op(32'h7fffffff, 32'h7fffffff, 1'b1, 1, 1'b0);
        do_op(32'h80000000, 32'h80000000, 1'b1, 1, 1'b0);
        do_op(32'hffffffff, 32'hffffffff, 1'b0, 1, 1'b0);
        do_op(32'h00000001, 32'h80000000, 1'b1, 1, 1'b0);
        do_op(32'h00000000, 32'h80000000, 1'b1, 1, 1'b0);
        do_op(32'hfffffff3, 32'h00000005, 1'b1, 1, 1'b0);

        // Level start held 40 cycles, then a second edge in the middle of CALC.
        do_op(32'h00001234, 32'hdeadbeef, 1'b0, 40, 1'b0);
        do_op(32'hffff0000, 32'h00abcdef, 1'b0, 1, 1'b1);

        // Reset 10 cycles into an operation must abort it silently.
        @(negedge clk);
        mlier = 32'hffffffff;
        mcand = 32'h12345678;
        sgn   = 1'b0;
        start = 1'b1;
        begin
            int e0;
            e0 = cyc + 1;
            @(negedge clk);
            start = 1'b0;
            while (cyc < e0 + 10) @(negedge clk);
        end
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("abort_prodt", prodt, 64'd0);
        chk("abort_valid", {63'd0, valid}, 64'd0);
        chk("abort_busy", {63'd0, busy}, 64'd0);

        // Start already high when reset releases counts as an edge on the first clock.
        mlier = 32'hfffffffe;
        mcand = 32'h00000003;
        sgn   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;
        e.p   = ref_prod(32'hfffffffe, 32'h00000003, 1'b1);
        e.cyc = cyc + 1 + ref_lat(32'hfffffffe, 1'b1);
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        for (int i = 0; i < 30; i++) begin
            logic [31:0] a, b;
            logic        s;
            a = rand_operand();
            b = rand_operand();
            s = 1'($urandom_range(0, 1));
            do_op(a, b, s, int'($urandom_range(1, 3)), 1'b0);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
